mult_share_scheduler: RTL and testbench
=======================================

# mult_share_scheduler

- Round-robin scheduler that lets two requesters share one iterative shift-add multiplier.
- Accepts a request/operand pair, runs an unsigned SIZE×SIZE multiply one multiplier bit per cycle, and returns the 2·SIZE-bit product with a done strobe to the owning requester.
- Sits between the arithmetic-experiment requesters and the multiplier datapath, replacing one combinational array per requester with a single time-shared unit.

## Interface
- Parameters:
  - SIZE, 16, operand width in bits (≥2).
- Ports:
  - Clock  in  1  rising-edge clock; the only clock.
  - Reset  in  1  synchronous, active-high reset.
  - iReq0  in  1  requester 0 wants a multiply; held until oGrant0.
  - iA0, iB0  in  SIZE  requester 0 multiplicand, multiplier; stable while iReq0 high.
  - iReq1  in  1  requester 1 request.
  - iA1, iB1  in  SIZE  requester 1 operands.
  - oGrant0, oGrant1  out  1  one-cycle accept pulse to the winner.
  - oDone0, oDone1  out  1  one-cycle product-valid pulse to the owner.
  - oResult  out  2·SIZE  product; valid in the done cycle, held until the next grant.
  - oBusy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when iReq0|iReq1 is high at a rising edge. The winner's operands are latched at that edge.
  - RUN → DONE after the last bit step.
  - DONE → IDLE unconditionally.
- Requests are sampled only in IDLE. Requests in RUN/DONE are neither granted nor queued.
- Arbitration: a last-served pointer, reset to 1 so requester 0 wins first.
  - Single request: that requester wins.
  - Both requests: the requester not last served wins.
  - The pointer updates on every grant.
- Datapath registers: ACC (2·SIZE), MCAND (2·SIZE, zero-extended A), MPLR (SIZE), CNT, OWNER.
- Each RUN cycle:
  - if MPLR[0], ACC ← ACC + MCAND;
  - then MCAND ← MCAND<<1, MPLR ← MPLR>>1, CNT ← CNT+1.
- Arithmetic is unsigned and the product cannot overflow 2·SIZE bits.
- Zero operands need no special case and yield 0.
- In DONE: oResult ← ACC, and oDoneOWNER = 1.
- A requester deasserts its iReq in its grant cycle. A request still high on return to IDLE is treated as a new request.
- Reset mid-operation:
  - FSM → IDLE, pointer → 1.
  - The aborted operation produces no oDone and the owner gets no indication.
  - Requester reissues after reset.
- Reset values: oGrant0/1 = 0, oDone0/1 = 0, oResult = 0, oBusy = 0, ACC = 0, CNT = 0.

## Timing
- Cycle 0 is the IDLE edge that samples the request.
- oGrantN is high in cycle 1, the first RUN cycle; oBusy is high from cycle 1.
- Fixed build: RUN occupies cycles 1..SIZE and DONE is cycle SIZE+1.
  - oDoneN and the new oResult appear in cycle SIZE+1.
  - IDLE is cycle SIZE+2; the next request can be sampled at that edge.
  - Back-to-back throughput is one product per SIZE+2 cycles.
- oGrant and oDone are registered, never combinational from iReq.
- A losing simultaneous request stays pending and is granted at the next IDLE edge.

## Configuration
- MULT_EARLY_EXIT_EN:
  - Defined: RUN exits after the cycle in which the post-shift MPLR is zero. RUN lasts k = max(1, index of highest set bit of B + 1) cycles, so done lands in cycle k+1.
  - Undefined: RUN always lasts SIZE cycles.
- Products are identical in both builds.

## Test plan
- SIZE=16, fixed build: iReq0 with A=3, B=5 → oGrant0 in cycle 1; oDone0 in cycle 17 with oResult=0x0000000F; oDone1 stays 0.
- A=0xFFFF, B=0xFFFF on requester 1 → oResult=0xFFFE0001 with oDone1 in cycle 17.
- iReq0 and iReq1 together from reset, held until granted → requester 0 granted first, done cycle 17; requester 1 granted in cycle 19, done cycle 35.
- Repeat the simultaneous request → order alternates.
- Reset asserted in cycle 8 of an operation → oBusy = 0 and oResult = 0 the next cycle, and no oDone ever appears for that operation.
- Early-exit build:
  - A=7, B=1 → oDone in cycle 2 with oResult=7.
  - A=2, B=0x8000 → oDone in cycle 17 with oResult=0x00010000.
  - A=9, B=0 → oDone in cycle 2 with oResult=0.

Source files
------------

// File: rtl/mult_share_scheduler.sv
// mult_share_scheduler
//   Two requesters share one iterative shift-add multiplier. A round-robin
//   pointer picks the winner when both ask at once. Each accepted request
//   runs an unsigned SIZE x SIZE multiply at one multiplier bit per cycle.
//   The 2*SIZE-bit product goes back to the owning requester with a one-cycle
//   done strobe.
//
//   Build option: MULT_EARLY_EXIT_EN
//     defined   - RUN ends in the cycle where the shifted multiplier becomes
//                 zero, so the latency follows the highest set bit of B.
//     undefined - RUN always lasts SIZE cycles.
//
//   Ports
//     Clock            rising-edge clock
//     Reset            synchronous, active-high
//     iReq0/iA0/iB0    requester 0 request, multiplicand, multiplier
//     iReq1/iA1/iB1    requester 1 request, multiplicand, multiplier
//     oGrant0/1        one-cycle accept pulse, first RUN cycle
//     oDone0/1         one-cycle product-valid pulse to the owner
//     oResult          product; held until the next completion
//     oBusy            high whenever the FSM is not IDLE
//
//   state  | meaning
//   IDLE   | waiting; requests are sampled and arbitrated here only
//   RUN    | one shift-add bit step per cycle
//   DONE   | product presented with the owner's done strobe
module mult_share_scheduler #(
  parameter int SIZE = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iReq0,
  input  logic [SIZE-1:0]     iA0,
  input  logic [SIZE-1:0]     iB0,
  input  logic                iReq1,
  input  logic [SIZE-1:0]     iA1,
  input  logic [SIZE-1:0]     iB1,
  output logic                oGrant0,
  output logic                oGrant1,
  output logic                oDone0,
  output logic                oDone1,
  output logic [2*SIZE-1:0]   oResult,
  output logic                oBusy
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q,  state_d;
  logic [2*SIZE-1:0]   acc_q,    acc_d;
  logic [2*SIZE-1:0]   mcand_q,  mcand_d;
  logic [SIZE-1:0]     mplr_q,   mplr_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic                owner_q,  owner_d;
  logic                last_q,   last_d;
  logic                grant0_q, grant0_d;
  logic                grant1_q, grant1_d;
  logic                done0_q,  done0_d;
  logic                done1_q,  done1_d;
  logic [2*SIZE-1:0]   result_q, result_d;

  logic                win1;
  logic [2*SIZE-1:0]   acc_sum;
  logic [SIZE-1:0]     mplr_shift;
  logic                last_step;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    win1       = iReq1 & (~iReq0 | ~last_q);
    acc_sum    = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mplr_shift = mplr_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
    last_step  = (cnt_q == CNT_LAST) || (mplr_shift == '0);
`else
    last_step  = (cnt_q == CNT_LAST);
`endif

    case (state_q)
      S_IDLE: begin
        if (iReq0 || iReq1) begin
          state_d  = S_RUN;
          owner_d  = win1;
          last_d   = win1;
          grant0_d = ~win1;
          grant1_d = win1;
          acc_d    = '0;
          cnt_d    = '0;
          mcand_d  = {{SIZE{1'b0}}, (win1 ? iA1 : iA0)};
          mplr_d   = win1 ? iB1 : iB0;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          // Load the product on the way into DONE so it is visible with the strobe.
          state_d  = S_DONE;
          result_d = acc_sum;
          done0_d  = ~owner_q;
          done1_d  = owner_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
    end
  end

  assign oGrant0 = grant0_q;
  assign oGrant1 = grant1_q;
  assign oDone0  = done0_q;
  assign oDone1  = done1_q;
  assign oResult = result_q;
  assign oBusy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Scoreboard bench for mult_share_scheduler (SIZE = 16). Drivers push the
// expected owner/product/latency for each request; a negedge monitor pops
// and compares whenever a done strobe appears.
module tb_mult_share_scheduler;

  localparam int SIZE = 16;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iReq0 = 1'b0;
  logic        iReq1 = 1'b0;
  logic [15:0] iA0 = '0, iB0 = '0, iA1 = '0, iB1 = '0;
  logic        oGrant0, oGrant1, oDone0, oDone1, oBusy;
  logic [31:0] oResult;

  mult_share_scheduler #(.SIZE(SIZE)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iReq0   (iReq0),
    .iA0     (iA0),
    .iB0     (iB0),
    .iReq1   (iReq1),
    .iA1     (iA1),
    .iB1     (iB1),
    .oGrant0 (oGrant0),
    .oGrant1 (oGrant1),
    .oDone0  (oDone0),
    .oDone1  (oDone1),
    .oResult (oResult),
    .oBusy   (oBusy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          owner;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   g_cyc    = 0;
  bit   last_ptr = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Number of RUN cycles the scheduler should spend for multiplier b.
  function automatic int lat_of(input logic [15:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return k;
`else
    return SIZE;
`endif
  endfunction

  always @(negedge Clock) begin : monitor
    exp_t e;
    if (!Reset) begin
      if (oGrant0 || oGrant1) g_cyc = cyc;
      if (oDone0 || oDone1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {62'd0, oDone1, oDone0}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_strobes", {62'd0, oDone1, oDone0}, (e.owner == 1) ? 64'd2 : 64'd1);
          check("result", {32'd0, oResult}, {32'd0, e.res});
          check("done_latency", 64'(cyc - g_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic push_exp(input int r, input logic [31:0] res, input logic [15:0] b);
    exp_t e;
    e.owner = r;
    e.res   = res;
    e.lat   = lat_of(b);
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int r, input logic v);
    if (r == 0) iReq0 = v;
    else        iReq1 = v;
  endtask

  task automatic wait_done(input logic [31:0] res);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (oDone0 || oDone1) break;
    end
    if (i == 100) check("done_timeout", 64'd0, 64'd1);
    @(negedge Clock);
    check("idle_busy", {63'd0, oBusy}, 64'd0);
    check("held_result", {32'd0, oResult}, {32'd0, res});
  endtask

  task automatic single(input int r, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] res);
    if (r == 0) begin iA0 = a; iB0 = b; end
    else        begin iA1 = a; iB1 = b; end
    set_req(r, 1'b1);
    push_exp(r, res, b);
    last_ptr = r[0];
    @(negedge Clock);
    check("grant", {62'd0, oGrant1, oGrant0}, (r == 1) ? 64'd2 : 64'd1);
    check("busy_in_run", {63'd0, oBusy}, 64'd1);
    set_req(r, 1'b0);
    wait_done(res);
  endtask

  task automatic both(input logic [15:0] a0, input logic [15:0] b0, input logic [31:0] r0,
                      input logic [15:0] a1, input logic [15:0] b1, input logic [31:0] r1);
    int w, l, g1, i;
    w = last_ptr ? 0 : 1;
    l = 1 - w;
    iA0 = a0; iB0 = b0; iA1 = a1; iB1 = b1;
    iReq0 = 1'b1;
    iReq1 = 1'b1;
    push_exp(w, (w == 0) ? r0 : r1, (w == 0) ? b0 : b1);
    push_exp(l, (l == 0) ? r0 : r1, (l == 0) ? b0 : b1);
    last_ptr = l[0];
    @(negedge Clock);
    check("first_grant", {62'd0, oGrant1, oGrant0}, (w == 1) ? 64'd2 : 64'd1);
    g1 = cyc;
    set_req(w, 1'b0);
    for (i = 0; i < 100; i++) begin
      @(negedge Clock);
      if ((l == 1) ? oGrant1 : oGrant0) break;
    end
    if (i == 100) check("second_grant_timeout", 64'd0, 64'd1);
    else check("second_grant_cycle", 64'(cyc - g1),
               64'(lat_of((w == 0) ? b0 : b1) + 2));
    set_req(l, 1'b0);
    wait_done((l == 0) ? r0 : r1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int done_seen;
    repeat (3) @(negedge Clock);
    check("rst_grants", {62'd0, oGrant1, oGrant0}, 64'd0);
    check("rst_dones", {62'd0, oDone1, oDone0}, 64'd0);
    check("rst_result", {32'd0, oResult}, 64'd0);
    check("rst_busy", {63'd0, oBusy}, 64'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // Both from reset: requester 0 first, then requester 1.
    both(16'd3, 16'd5, 32'h0000_000F, 16'h1234, 16'h5678, 32'h0626_0060);
    single(0, 16'd3, 16'd5, 32'h0000_000F);
    // Requester 0 served last, so requester 1 now goes first.
    both(16'd6, 16'd7, 32'd42, 16'd100, 16'd200, 32'd20000);
    single(1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // Abort: reset asserted in cycle 8 of an operation.
    iA0 = 16'd11; iB0 = 16'd13;
    iReq0 = 1'b1;
    @(negedge Clock);
    check("abort_grant", {62'd0, oGrant1, oGrant0}, 64'd1);
    iReq0 = 1'b0;
    repeat (7) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_busy", {63'd0, oBusy}, 64'd0);
    check("abort_result", {32'd0, oResult}, 64'd0);
    Reset = 1'b0;
    last_ptr = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge Clock);
      if (oDone0 || oDone1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Pointer was reset: requester 0 wins again.
    both(16'd1000, 16'd3, 32'd3000, 16'd2, 16'd2, 32'd4);

    single(0, 16'd7, 16'd1, 32'd7);
    single(1, 16'd2, 16'h8000, 32'h0001_0000);
    single(0, 16'd9, 16'd0, 32'd0);
    single(1, 16'd0, 16'hABCD, 32'd0);

    repeat (3) @(negedge Clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
